// File: rtl/popcount_pattern_gen.sv
// popcount_pattern_gen
// Accepts a one-hot weight code {v,w,x,y,z} (0..4 ones) and emits every
// 4-bit word with that many ones in ascending order, one per output
// handshake. It is the inverse of the 4-input ones-counter and feeds it
// round-trip stimulus.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a weight code; in_ready follows ena
//   RUN   | presenting out_word; advances on each output transfer
module popcount_pattern_gen #(
  parameter bit ERR_STICKY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_word,
  output logic [2:0] out_index,
  output logic       out_last,
  output logic       err,
  output logic       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_k;
  logic [3:0] r_word;
  logic [2:0] r_index;
  logic       r_last;
  logic       r_err;

  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_code_ok;
  logic [2:0] w_code_k;
  logic [3:0] w_first_word;
  logic [3:0] w_next_word;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Largest word of weight k: k ones packed against the MSB.
  function automatic logic [3:0] last_word_of(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  assign in_ready   = (r_state == S_IDLE) & ena;
  assign out_valid  = (r_state == S_RUN) & ena;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign out_word  = r_word;
  assign out_index = r_index;
  assign out_last  = r_last;
  assign err       = r_err;
  assign busy      = (r_state == S_RUN);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_code_ok = (in_code != 5'd0) && ((in_code & (in_code - 5'd1)) == 5'd0);

  // Decode the one-hot weight code (v is weight 0, z is weight 4) and the
  // first word of that weight, (1<<k)-1.
  always_comb begin
    w_code_k     = 3'd4;
    w_first_word = 4'b1111;
    case (in_code)
      5'b10000: begin w_code_k = 3'd0; w_first_word = 4'b0000; end
      5'b01000: begin w_code_k = 3'd1; w_first_word = 4'b0001; end
      5'b00100: begin w_code_k = 3'd2; w_first_word = 4'b0011; end
      5'b00010: begin w_code_k = 3'd3; w_first_word = 4'b0111; end
      default:  begin w_code_k = 3'd4; w_first_word = 4'b1111; end
    endcase
  end

  // Smallest word above r_word with the same popcount; scanning downward
  // lets the last match win.
  always_comb begin
    w_next_word = r_word;
    for (int j = 15; j >= 0; j--) begin
      if ((4'(j) > r_word) && (pop4(4'(j)) == r_k)) begin
        w_next_word = 4'(j);
      end
    end
  end

  // Sequencer: loads a weight, walks same-weight words, flags bad codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_word  <= 4'd0;
      r_index <= 3'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (ena) begin
      // err pulses once per rejected code; ena=0 holds it, stretching the pulse.
      r_err <= (ERR_STICKY & r_err) | (w_in_fire & ~w_code_ok);
      case (r_state)
        S_IDLE: begin
          if (w_in_fire && w_code_ok) begin
            r_state <= S_RUN;
            r_k     <= w_code_k;
            r_word  <= w_first_word;
            r_index <= 3'd0;
            r_last  <= (w_first_word == last_word_of(w_code_k));
          end
        end
        S_RUN: begin
          if (w_out_fire) begin
            if (r_last) begin
              r_state <= S_IDLE;
            end else begin
              r_word  <= w_next_word;
              r_index <= r_index + 3'd1;
              r_last  <= (w_next_word == last_word_of(r_k));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
